// File: rtl/rotate_scheduler_if.sv
// Requester/consumer bundle for rotate_scheduler: two rotate requesters and one result consumer.
interface rotate_scheduler_if #(
  parameter int AMT_W = 4
);
  logic             req_a;
  logic             req_b;
  logic [3:0]       data_a;
  logic [3:0]       data_b;
  logic [AMT_W-1:0] amt_a;
  logic [AMT_W-1:0] amt_b;
  logic             gnt_a;
  logic             gnt_b;
  logic             busy;
  logic             out_valid;
  logic [3:0]       out_data;
  logic             out_id;
  logic             out_ready;

  modport master (
    output req_a, req_b, data_a, data_b, amt_a, amt_b, out_ready,
    input  gnt_a, gnt_b, busy, out_valid, out_data, out_id
  );

  modport slave (
    input  req_a, req_b, data_a, data_b, amt_a, amt_b, out_ready,
    output gnt_a, gnt_b, busy, out_valid, out_data, out_id
  );
endinterface

// File: rtl/rotate_scheduler.sv
// Two-requester 4-bit rotate-right engine using a 0..3 barrel shifter over multiple passes.
// Optional RR_ARB_EN: round-robin tie-break between A and B (default: fixed priority to A).
module barrelShifter (
  input  logic [3:0] din,
  input  logic [1:0] shamt,
  output logic [3:0] dout
);
  logic [7:0] dbl;

  assign dbl  = {din, din};
  assign dout = 4'(dbl >> shamt);
endmodule

module rotate_scheduler #(
  parameter int AMT_W = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  rotate_scheduler_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ROTATE, HOLD} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       work;
  logic [AMT_W-1:0] rem;
  logic [AMT_W-1:0] rem_nxt;
  logic [AMT_W-1:0] amt_sel;
  logic [1:0]       step;
  logic [3:0]       shifted;
  logic             id;
  logic             tie_to_a;
  logic             gnt_a;
  logic             gnt_b;
  logic             gnt_any;

`ifdef RR_ARB_EN
  // Set when B won the most recent grant; reset value makes the first tie go to A.
  logic last_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
    end else if (gnt_any) begin
      last_b <= gnt_b;
    end
  end

  assign tie_to_a = last_b;
`else
  assign tie_to_a = 1'b1;
`endif

  // Grants are gated by rst_n so nothing is offered while reset is held.
  assign gnt_a   = rst_n && (state == IDLE) && bus.req_a && (!bus.req_b || tie_to_a);
  assign gnt_b   = rst_n && (state == IDLE) && bus.req_b && (!bus.req_a || !tie_to_a);
  assign gnt_any = gnt_a || gnt_b;
  assign amt_sel = gnt_b ? bus.amt_b : bus.amt_a;

  assign step    = (rem > AMT_W'(3)) ? 2'd3 : rem[1:0];
  assign rem_nxt = rem - AMT_W'(step);

  barrelShifter u_shifter (
    .din   (work),
    .shamt ((state == ROTATE) ? step : 2'd0),
    .dout  (shifted)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          state_nxt = (amt_sel != '0) ? ROTATE : HOLD;
        end
      end
      ROTATE: begin
        if (rem_nxt == '0) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      rem   <= '0;
      id    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt_any) begin
        work <= gnt_b ? bus.data_b : bus.data_a;
        rem  <= amt_sel;
        id   <= gnt_b;
      end else if (state == ROTATE) begin
        work <= shifted;
        rem  <= rem_nxt;
      end
    end
  end

  assign bus.gnt_a     = gnt_a;
  assign bus.gnt_b     = gnt_b;
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_data  = work;
  assign bus.out_id    = id;
endmodule

// File: doc/rotate_scheduler.md
ROTATE_SCHEDULER -- requirements
Module: rotate_scheduler

Interface
REQ-001 Parameter: AMT_W, 4, width of the rotate-amount inputs (rotation range 0..2^AMT_W-1).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_a, req_b  input  1 each  rotate request from requester A and B.
REQ-005 Port: data_a, data_b  input  4 each  word to rotate.
REQ-006 Port: amt_a, amt_b  input  AMT_W each  rotate-right amount.
REQ-007 Port: gnt_a, gnt_b  output  1 each  grant; request and operands captured on the edge where grant is high.
REQ-008 Port: busy  output  1  high in any state other than IDLE.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_data  output  4  rotated word.
REQ-011 Port: out_id  output  1  owner of result; 0 = A, 1 = B.
REQ-012 Port: out_ready  input  1  consumer accepts result.

Function
REQ-013 The block SHALL instantiate one barrelShifter and apply it only to its internal work register; per pass, it rotates right by S, where S is 0..3, and bit i of the result equals work[(i+S) mod 4].
REQ-014 The FSM SHALL have exactly three states, IDLE, ROTATE and HOLD.
REQ-015 Grants SHALL be combinational and asserted only in IDLE, at most one at a time, and only to an asserting requester.
REQ-016 On the grant edge, the block SHALL latch the data into work, the amount into rem, and the requester into out_id.
REQ-017 After a grant, the next state SHALL be ROTATE if amt != 0 and HOLD if amt == 0.
REQ-018 In each ROTATE cycle, the block SHALL drive S = min(rem,3), load the shifter output into work, and set rem to rem-S.
REQ-019 ROTATE SHALL go to HOLD in the cycle where rem-S == 0, and SHALL stay in ROTATE otherwise.
REQ-020 Latency: for a grant at edge N, out_valid SHALL rise after edge N+1+ceil(amt/3); for amt=0, it rises after edge N+1.
REQ-021 In HOLD, the block SHALL assert out_valid with out_data = work; out_data and out_id SHALL stay stable until accepted.
REQ-022 A HOLD cycle with out_ready=1 SHALL complete the transfer, and the next state SHALL be IDLE.
REQ-023 A new grant SHALL NOT occur before the cycle after the transfer; that is, there is no same-cycle turnaround.
REQ-024 Requests arriving in ROTATE or HOLD SHALL be ignored (no grant), and requesters SHALL hold req and operands until granted.
REQ-025 out_valid SHALL be 0 in IDLE and ROTATE.
REQ-026 Final out_data SHALL equal the input rotated right by (amt mod 4); amounts of 4 or more still take the full multi-pass latency.
REQ-027 If both requests are asserted in IDLE, arbitration SHALL follow REQ-030/REQ-031.

Reset
REQ-028 Asserting rst_n low SHALL immediately force IDLE, clear work, rem and out_id to 0, drive out_valid, gnt_a, gnt_b and busy to 0, and point the last-grant pointer to B.
REQ-029 Reset during ROTATE or HOLD SHALL discard the in-flight operation without producing output; the first grant after reset release SHALL follow the REQ-030/REQ-031 rules.

Configuration
REQ-030 With RR_ARB_EN defined, ties SHALL go to the requester not granted last (round-robin), the pointer SHALL update on every grant, and the first tie after reset SHALL go to A.
REQ-031 Without RR_ARB_EN, ties SHALL always go to A (fixed priority), and no pointer register SHALL exist.

Verification
REQ-032 The bench SHALL cover: req_a=1, data_a=4'b1000, amt_a=1, out_ready=1 -> gnt_a for 1 cycle, out_valid two edges later, out_data=4'b0100, out_id=0.
REQ-033 The bench SHALL cover: req_b=1, data_b=4'b1011, amt_b=7 -> 3 ROTATE cycles (S=3,3,1), out_data=4'b0111 (rotate right by 3), out_id=1.
REQ-034 The bench SHALL cover: amt_a=0, data_a=4'b0110 -> HOLD directly after grant, out_data=4'b0110; with out_ready=0 for 5 cycles, out_valid and out_data SHALL stay stable.
REQ-035 The bench SHALL cover: req_a and req_b held continuously with amt=2 -> with RR_ARB_EN the grant order is A,B,A,B; without it, the grant order is A,A,A.
REQ-036 The bench SHALL cover: rst_n pulsed low mid-ROTATE (amt=15) -> out_valid never rises, busy=0 immediately, and the next request is granted normally.
